// File: rtl/core_mem_pkg.sv
// Shared encodings for the core-side memory arbiter: FSM states, requester ids
// and the full-word byte-enable used for reads.
`timescale 1ns/1ps
package core_mem_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;

  localparam logic [1:0] REQ_INST   = 2'd0;
  localparam logic [1:0] REQ_DREAD  = 2'd1;
  localparam logic [1:0] REQ_DWRITE = 2'd2;

  localparam logic [3:0] MEM_STRB_FULL = 4'hf;
endpackage

// File: rtl/mem_arb_select.sv
// Fixed-priority requester select (write > read > fetch) with a fetch override
// once the starvation counter has hit its limit. Purely combinational.
`timescale 1ns/1ps
module mem_arb_select
  import core_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic       starve,
  output logic [2:0] gnt
);
  always_comb begin
    gnt = 3'b000;
    if (starve && req[REQ_INST]) begin
      gnt[REQ_INST] = 1'b1;
    end else if (req[REQ_DWRITE]) begin
      gnt[REQ_DWRITE] = 1'b1;
    end else if (req[REQ_DREAD]) begin
      gnt[REQ_DREAD] = 1'b1;
    end else if (req[REQ_INST]) begin
      gnt[REQ_INST] = 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch, data read
// and data write; returns completions as registered one-cycle pulses.
`timescale 1ns/1ps
module mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_rden,
  input  logic [31:0] inst_raddr,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  output logic        inst_wait,
  input  logic        data_rden,
  input  logic [31:0] data_raddr,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  input  logic        data_wren,
  input  logic [31:0] data_waddr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_wdone,
  output logic        data_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strb,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  state;
  logic [1:0]  owner;
  logic [3:0]  starve_cnt;
  logic [2:0]  req;
  logic [2:0]  gnt;
  logic        starve;
  logic        done_pulse;
  logic        grant;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;

  assign req        = {data_wren, data_rden, inst_rden};
  assign starve     = (starve_cnt == LIMIT);
  assign done_pulse = inst_rvalid | data_rvalid | data_wdone;
  // The completing requester still holds its request during the pulse cycle,
  // so no grant is made then; this also enforces one IDLE cycle between jobs.
  assign grant      = (state == IDLE) && !done_pulse && (|req);

  mem_arb_select u_select (
    .req    (req),
    .starve (starve),
    .gnt    (gnt)
  );

  assign mem_req   = (state == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_strb  = strb_q;

  assign inst_wait = inst_rden & ~inst_rvalid;
  assign data_wait = (data_rden & ~data_rvalid) | (data_wren & ~data_wdone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= REQ_INST;
      starve_cnt  <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      strb_q      <= 4'd0;
      inst_rvalid <= 1'b0;
      inst_rdata  <= 32'd0;
      data_rvalid <= 1'b0;
      data_rdata  <= 32'd0;
      data_wdone  <= 1'b0;
    end else begin
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      data_wdone  <= 1'b0;

      if (!inst_rden) begin
        starve_cnt <= 4'd0;
      end else if (grant) begin
        if (gnt[REQ_INST]) begin
          starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end

      case (state)
        IDLE: begin
          if (grant) begin
            state <= ISSUE;
            if (gnt[REQ_DWRITE]) begin
              owner   <= REQ_DWRITE;
              we_q    <= 1'b1;
              addr_q  <= data_waddr;
              wdata_q <= data_wdata;
              strb_q  <= data_wstrb;
            end else begin
              owner   <= gnt[REQ_DREAD] ? REQ_DREAD : REQ_INST;
              we_q    <= 1'b0;
              addr_q  <= gnt[REQ_DREAD] ? data_raddr : inst_raddr;
              wdata_q <= 32'd0;
              strb_q  <= MEM_STRB_FULL;
            end
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            if (we_q) begin
              data_wdone <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (owner == REQ_INST) begin
              inst_rdata  <= mem_rdata;
              inst_rvalid <= 1'b1;
            end else begin
              data_rdata  <= mem_rdata;
              data_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small memory model (configurable ack
// delay, holdable read response) and hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inst_rden = 1'b0;
  logic [31:0] inst_raddr = 32'd0;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        inst_wait;
  logic        data_rden = 1'b0;
  logic [31:0] data_raddr = 32'd0;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_wren = 1'b0;
  logic [31:0] data_waddr = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic [3:0]  data_wstrb = 4'd0;
  logic        data_wdone;
  logic        data_wait;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:255];
  int          ack_delay = 0;
  int          wcnt = 0;
  int          req_cnt = 0;
  bit          req_prev = 1'b0;
  bit          rd_pend = 1'b0;
  bit          hold_rsp = 1'b0;
  logic [31:0] rd_q = 32'd0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_rden(inst_rden), .inst_raddr(inst_raddr), .inst_rvalid(inst_rvalid),
    .inst_rdata(inst_rdata), .inst_wait(inst_wait),
    .data_rden(data_rden), .data_raddr(data_raddr), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_wren(data_wren), .data_waddr(data_waddr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_wdone(data_wdone),
    .data_wait(data_wait), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[64]  = 32'hdead_beef;  // 0x100
    mem[128] = 32'h0bad_f00d;  // 0x200
    mem[32]  = 32'h1111_2222;  // 0x80
  end

  // Memory model: drives ack/response 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (rd_pend && !hold_rsp) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_q;
      rd_pend    = 1'b0;
    end
    if (mem_req) begin
      if (!req_prev) req_cnt++;
      if (wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_strb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          rd_pend = 1'b1;
          rd_q    = mem[mem_addr[9:2]];
        end
      end else begin
        wcnt++;
      end
    end
    req_prev = mem_req;
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    tests++;
    if ({mem_req, mem_we, inst_rvalid, data_rvalid, data_wdone, inst_wait, data_wait} !== 7'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {mem_req, mem_we, inst_rvalid, data_rvalid, data_wdone, inst_wait, data_wait});
    end
    tests++;
    if ({mem_addr, mem_wdata, mem_strb} !== 68'd0) begin
      fails++;
      $display("FAIL reset_mem_fields: got %h/%h/%h expected 0", mem_addr, mem_wdata, mem_strb);
    end
    tests++;
    if ({inst_rdata, data_rdata} !== 64'd0) begin
      fails++;
      $display("FAIL reset_rdata: got %h/%h expected 0", inst_rdata, data_rdata);
    end
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_fetch;
    step;  // cycle 0
    inst_rden  = 1'b1;
    inst_raddr = 32'h100;
    #1;
    tests++;
    if ({inst_wait, mem_req} !== 2'b10) begin
      fails++; $display("FAIL fetch_c0: wait/req got %b expected 10", {inst_wait, mem_req});
    end
    step; #1;  // cycle 1
    tests++;
    if ({mem_req, mem_we, mem_strb, inst_wait} !== 7'b1011111 || mem_addr !== 32'h100) begin
      fails++; $display("FAIL fetch_c1: req/we/strb/wait %b addr %h expected 1011111 addr 100",
                        {mem_req, mem_we, mem_strb, inst_wait}, mem_addr);
    end
    step; #1;  // cycle 2
    tests++;
    if ({mem_req, inst_rvalid, inst_wait} !== 3'b001) begin
      fails++; $display("FAIL fetch_c2: req/rvalid/wait got %b expected 001", {mem_req, inst_rvalid, inst_wait});
    end
    step; #1;  // cycle 3
    tests++;
    if ({inst_rvalid, inst_wait} !== 2'b10 || inst_rdata !== 32'hdead_beef) begin
      fails++; $display("FAIL fetch_c3: rvalid/wait %b data %h expected 10 deadbeef",
                        {inst_rvalid, inst_wait}, inst_rdata);
    end
    inst_rden = 1'b0;
    step; #1;  // cycle 4
    tests++;
    if (inst_rvalid !== 1'b0 || mem_req !== 1'b0 || inst_rdata !== 32'hdead_beef) begin
      fails++; $display("FAIL fetch_hold: rvalid %b req %b data %h expected 0 0 deadbeef",
                        inst_rvalid, mem_req, inst_rdata);
    end
  endtask

  task automatic test_write_then_read;
    step;  // cycle 0
    data_wren  = 1'b1; data_waddr = 32'h40; data_wdata = 32'h1234_5678; data_wstrb = 4'h3;
    data_rden  = 1'b1; data_raddr = 32'h40;
    #1;
    tests++;
    if (data_wait !== 1'b1) begin
      fails++; $display("FAIL wr_c0_wait: got %b expected 1", data_wait);
    end
    step; #1;  // cycle 1
    tests++;
    if ({mem_req, mem_we, mem_strb} !== 6'b110011 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234_5678) begin
      fails++; $display("FAIL wr_issue: req/we/strb %b addr %h wdata %h expected 110011 40 12345678",
                        {mem_req, mem_we, mem_strb}, mem_addr, mem_wdata);
    end
    step; #1;  // cycle 2
    tests++;
    if ({data_wdone, data_wait} !== 2'b11) begin
      fails++; $display("FAIL wr_done: wdone/wait got %b expected 11", {data_wdone, data_wait});
    end
    data_wren = 1'b0;
    step; #1;  // cycle 3
    tests++;
    if ({mem_req, data_wdone} !== 2'b00) begin
      fails++; $display("FAIL gap_idle: req/wdone got %b expected 00", {mem_req, data_wdone});
    end
    step; #1;  // cycle 4
    tests++;
    if ({mem_req, mem_we, mem_strb} !== 6'b101111 || mem_addr !== 32'h40) begin
      fails++; $display("FAIL rd_issue: req/we/strb %b addr %h expected 101111 40",
                        {mem_req, mem_we, mem_strb}, mem_addr);
    end
    step;      // cycle 5
    step; #1;  // cycle 6
    tests++;
    if ({data_rvalid, data_wait} !== 2'b10 || data_rdata !== 32'h0000_5678) begin
      fails++; $display("FAIL rd_data: rvalid/wait %b data %h expected 10 00005678",
                        {data_rvalid, data_wait}, data_rdata);
    end
    data_rden = 1'b0;
    step;
  endtask

  task automatic test_starvation;
    int          ndata;
    int          ndata_at_fetch;
    bit          seen_fetch;
    bit          done;
    bit          prev;
    logic [3:0]  cnt_at_fetch;
    ndata = 0; ndata_at_fetch = -1; seen_fetch = 1'b0; done = 1'b0; prev = 1'b0;
    cnt_at_fetch = 4'hx;
    step;
    inst_rden = 1'b1; inst_raddr = 32'h200;
    data_rden = 1'b1; data_raddr = 32'h80;
    for (int c = 0; c < 80 && !done; c++) begin
      step; #1;
      if (mem_req && !prev) begin
        if (mem_addr == 32'h200) begin
          if (!seen_fetch) begin
            seen_fetch     = 1'b1;
            ndata_at_fetch = ndata;
            cnt_at_fetch   = dut.starve_cnt;
          end
        end else if (!seen_fetch) begin
          ndata++;
        end
      end
      prev = mem_req;
      if (inst_rvalid) begin
        done = 1'b1;
        tests++;
        if (inst_rdata !== 32'h0bad_f00d) begin
          fails++; $display("FAIL starve_fetch_data: got %h expected 0badf00d", inst_rdata);
        end
      end
    end
    inst_rden = 1'b0;
    data_rden = 1'b0;
    tests++;
    if (!done) begin
      fails++; $display("FAIL starve_timeout: fetch completed %b expected 1", done);
    end
    tests++;
    if (ndata_at_fetch !== 4) begin
      fails++; $display("FAIL starve_data_grants: got %0d expected 4", ndata_at_fetch);
    end
    tests++;
    if (cnt_at_fetch !== 4'd0) begin
      fails++; $display("FAIL starve_cnt_clear: got %h expected 0", cnt_at_fetch);
    end
    // Let any data read that was granted alongside the fetch drain out.
    for (int c = 0; c < 8; c++) step;
  endtask

  task automatic test_ack_delay;
    int base;
    base = req_cnt;
    ack_delay = 3;
    step;  // cycle 0
    data_wren = 1'b1; data_waddr = 32'h44; data_wdata = 32'hcafe_babe; data_wstrb = 4'hf;
    for (int c = 1; c <= 4; c++) begin
      step; #1;
      tests++;
      if ({mem_req, mem_we, data_wdone} !== 3'b110 || mem_addr !== 32'h44 || mem_wdata !== 32'hcafe_babe) begin
        fails++; $display("FAIL ackdly_stable_c%0d: req/we/wdone %b addr %h wdata %h expected 110 44 cafebabe",
                          c, {mem_req, mem_we, data_wdone}, mem_addr, mem_wdata);
      end
      if (c == 2) data_wren = 1'b0;
    end
    step; #1;  // cycle 5
    tests++;
    if ({data_wdone, mem_req} !== 2'b10) begin
      fails++; $display("FAIL ackdly_done: wdone/req got %b expected 10", {data_wdone, mem_req});
    end
    step; step; #1;
    tests++;
    if (req_cnt - base !== 1) begin
      fails++; $display("FAIL ackdly_single_req: got %0d requests expected 1", req_cnt - base);
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_read;
    bit bad;
    bit got;
    hold_rsp = 1'b1;
    step;  // cycle 0
    data_rden = 1'b1; data_raddr = 32'h80;
    step; step; step; #1;  // cycle 3, WAIT_R with response held
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_req, data_rvalid, inst_rvalid, data_wdone} !== 4'b0000 || data_rdata !== 32'd0 || mem_addr !== 32'd0) begin
      fails++; $display("FAIL mid_reset_outputs: ctrl %b rdata %h addr %h expected 0000 0 0",
                        {mem_req, data_rvalid, inst_rvalid, data_wdone}, data_rdata, mem_addr);
    end
    data_rden = 1'b0;
    step;
    rst_n    = 1'b1;
    hold_rsp = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step; #1;
      if (data_rvalid || inst_rvalid || mem_req) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++; $display("FAIL stray_rvalid: spurious activity %b expected 0", bad);
    end
    step;
    inst_rden = 1'b1; inst_raddr = 32'h100;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step; #1;
      if (inst_rvalid) got = 1'b1;
    end
    tests++;
    if (got !== 1'b1 || inst_rdata !== 32'hdead_beef) begin
      fails++; $display("FAIL post_reset_fetch: done %b data %h expected 1 deadbeef", got, inst_rdata);
    end
    inst_rden = 1'b0;
    step;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_then_read();
    test_starvation();
    test_ack_delay();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one memory interface between the core's instruction fetch, data read (mread) and data write (mwrite) requesters. It holds at most one outstanding transaction and grants by fixed priority with an anti-starvation counter. It returns read data and completion pulses to the owning requester, and drives per-requester wait signals that stall the core pipeline. It sits between `core` and the memory/bus adapter.

## Interface
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (1..15)
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-low
- INST_RDEN  in  1  fetch read request, held until INST_RVALID
- INST_RADDR  in  32  fetch address
- INST_RVALID  out  1  fetch data valid, 1-cycle pulse
- INST_RDATA  out  32  fetch data
- INST_WAIT  out  1  fetch request pending and not yet completed
- DATA_RDEN  in  1  data read request, held until DATA_RVALID
- DATA_RADDR  in  32  data read address
- DATA_RVALID  out  1  data read valid, 1-cycle pulse
- DATA_RDATA  out  32  data read data
- DATA_WREN  in  1  data write request, held until DATA_WDONE
- DATA_WADDR / DATA_WDATA  in  32 / 32  write address / data
- DATA_WSTRB  in  4  byte enables
- DATA_WDONE  out  1  write accepted, 1-cycle pulse
- DATA_WAIT  out  1  data read or write pending and not yet completed
- MEM_REQ  out  1  memory request, held until MEM_ACK
- MEM_WE  out  1  1 = write
- MEM_ADDR / MEM_WDATA  out  32 / 32  request address / write data
- MEM_STRB  out  4  byte enables (4'hf for reads)
- MEM_ACK  in  1  request accepted this cycle
- MEM_RVALID  in  1  read response valid
- MEM_RDATA  in  32  read response data

## Operation
- FSM: IDLE, ISSUE, WAIT_R.
- IDLE: sample requests and pick a winner.
  - Priority: DATA_WREN > DATA_RDEN > INST_RDEN.
  - If starve_cnt == STARVE_LIMIT and INST_RDEN is high, fetch wins.
  - The winner's id, address, data and strobe are latched; go to ISSUE.
- ISSUE: MEM_REQ = 1 with the latched fields. On MEM_ACK:
  - write: pulse DATA_WDONE next cycle, then go to IDLE.
  - read: go to WAIT_R.
- WAIT_R: on MEM_RVALID, register MEM_RDATA into the owner's RDATA and pulse the owner's RVALID next cycle; go to IDLE.
- starve_cnt (4 bits):
  - +1 on each data grant made while INST_RDEN is high, saturating at STARVE_LIMIT.
  - Cleared on a fetch grant or when INST_RDEN is low.
- *_WAIT = request input high AND the completion pulse for it is not asserted this cycle.
- Requester RDATA holds its last value between pulses.

## Timing
- Reset (RST = 0, async): state IDLE, starve_cnt 0, all outputs 0, latched fields 0.
- Best-case read: request at cycle 0, MEM_REQ at 1, MEM_ACK at 1, MEM_RVALID at 2, requester RVALID at 3.
- Best-case write: request at 0, MEM_REQ at 1, MEM_ACK at 1, DATA_WDONE at 2.
- Back-to-back: a new grant happens no earlier than the cycle after the completion pulse, so there is at least one IDLE cycle between transactions.
- MEM_REQ and its fields stay stable until MEM_ACK; a requester dropping its request after grant does not abort the transaction.
- MEM_RVALID outside WAIT_R is ignored, including stray responses after a mid-transaction reset.
- MEM_ACK outside ISSUE is ignored.
- Reset mid-ISSUE or mid-WAIT_R: MEM_REQ drops immediately and no completion pulse is issued.
- Write and read pending together: the write goes first, giving store-before-load ordering.

## Structure
- Shared package `core_mem_pkg`:
  - state encodings (IDLE = 2'd0, ISSUE = 2'd1, WAIT_R = 2'd2)
  - requester ids (REQ_INST = 2'd0, REQ_DREAD = 2'd1, REQ_DWRITE = 2'd2)
  - MEM_STRB_FULL = 4'hf
- One natural sub-module, `mem_arb_select`: combinational priority plus starvation override, taking request vector and starve flag and returning a one-hot grant.

## Test plan
- Single fetch, INST_RADDR = 32'h100, memory returns 32'hdead_beef with zero wait: INST_RVALID pulses at cycle 3 with that data, and INST_WAIT is high during cycles 0-2.
- DATA_WREN and DATA_RDEN asserted together to address 32'h40: the write is issued first (MEM_WE = 1, then DATA_WDONE); the read follows and DATA_RVALID returns the written value from the memory model.
- INST_RDEN held with continuous data reads, STARVE_LIMIT = 4: exactly 4 data grants, then a fetch grant, and starve_cnt returns to 0.
- MEM_ACK delayed 3 cycles: MEM_REQ, MEM_ADDR and MEM_WDATA stay stable throughout, with no duplicate request.
- RST pulled low during WAIT_R: outputs go to 0 immediately; a late MEM_RVALID after release produces no RVALID pulse; the next request completes normally.
